// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit and state machine for the multicycle RV32 processor. Decodes
// opcode, funct3 and funct7[5] of the current instruction into ALU and
// datapath controls. Sequences IF -> ID -> EX -> (MEM) -> WB, with optional
// ready handshakes on instruction and data memory.
//
// Parameters:
//   SKIP_MEM      1: non-load/store instructions go EX -> WB directly
//                 0: every instruction passes through MEM
//   USE_HANDSHAKE 1: IF waits on iReady, load/store MEM waits on dReady
//                 0: ready inputs are treated as always high
//   CNT_W         width of the retired-instruction counter
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   instr         current instruction, stable from ID through WB
//   iReady        instruction memory ready
//   dReady        data memory ready
//   Zero, Lt      ALU zero flag and signed rs1 < rs2 from the datapath
//   ALUCtrl       ALU operation select
//   ALUSrc        ALU operand B: 0 = rs2, 1 = immediate
//   RegWrite      register file write enable (WB only)
//   MemToReg      writeback from data memory (WB only)
//   MemRead       data memory read strobe (MEM only)
//   MemWrite      data memory write strobe (MEM only)
//   loadPC        PC update enable (WB only)
//   PCSrc         take branch target (WB only)
//   state         current state: IF=0, ID=1, EX=2, MEM=3, WB=4
//   illegal       unsupported opcode or branch funct3 (WB only)
//   instret       count of retired instructions, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter bit SKIP_MEM      = 1'b1,
   parameter bit USE_HANDSHAKE = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             iReady,
   input  logic             dReady,
   input  logic             Zero,
   input  logic             Lt,
   output logic [3:0]       ALUCtrl,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic             MemToReg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             loadPC,
   output logic             PCSrc,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   state_t cur_state;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       is_r, is_i, is_s, is_b, is_lw, is_mem;
   logic       branch_ok, branch_cond;
   logic       i_ready_eff, d_ready_eff;
   logic       in_mem, in_wb;
   logic       unused_instr_bits;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7_5 = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   assign is_r   = (opcode == 7'b0110011);
   assign is_i   = (opcode == 7'b0010011);
   assign is_s   = (opcode == 7'b0100011);
   assign is_b   = (opcode == 7'b1100011);
   assign is_lw  = (opcode == 7'b0000011);
   assign is_mem = is_s | is_lw;

   // Without handshaking the memories are assumed to answer immediately.
   assign i_ready_eff = USE_HANDSHAKE ? iReady : 1'b1;
   assign d_ready_eff = USE_HANDSHAKE ? dReady : 1'b1;

   // Only BEQ/BNE/BLT/BGE are supported; any other branch funct3 is flagged
   // illegal and never taken.
   always_comb begin
      branch_ok   = 1'b0;
      branch_cond = 1'b0;
      case (funct3)
         3'b000:  begin branch_ok = 1'b1; branch_cond = Zero;  end
         3'b001:  begin branch_ok = 1'b1; branch_cond = ~Zero; end
         3'b100:  begin branch_ok = 1'b1; branch_cond = Lt;    end
         3'b101:  begin branch_ok = 1'b1; branch_cond = ~Lt;   end
         default: begin branch_ok = 1'b0; branch_cond = 1'b0;  end
      endcase
   end

   // ALU operation decode. funct7[5] selects SUB only for R-type; for I-type
   // it only distinguishes SRAI from SRLI. The ALU has no unsigned compare,
   // so funct3=011 falls back to signed SLT.
   always_comb begin
      ALUCtrl = ALU_ADD;
      if (is_r || is_i) begin
         case (funct3)
            3'b000:  ALUCtrl = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  ALUCtrl = ALU_SLL;
            3'b010:  ALUCtrl = ALU_SLT;
            3'b011:  ALUCtrl = ALU_SLT;
            3'b100:  ALUCtrl = ALU_XOR;
            3'b101:  ALUCtrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  ALUCtrl = ALU_OR;
            default: ALUCtrl = ALU_AND;
         endcase
      end else if (is_b) begin
         ALUCtrl = ALU_SUB;
      end
   end

   assign ALUSrc = ~(is_r | is_b);

   // State sequencing and retired-instruction counter. Reset forces IF and
   // clears the counter immediately; the counter ticks on every WB exit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state <= S_IF;
         instret   <= '0;
      end else begin
         case (cur_state)
            S_IF:    if (i_ready_eff) cur_state <= S_ID;
            S_ID:    cur_state <= S_EX;
            S_EX:    cur_state <= (is_mem || !SKIP_MEM) ? S_MEM : S_WB;
            S_MEM:   if (!is_mem || d_ready_eff) cur_state <= S_WB;
            S_WB: begin
               cur_state <= S_IF;
               instret   <= instret + CNT_W'(1);
            end
            default: cur_state <= S_IF;
         endcase
      end
   end

   // Strobes are decoded straight from the state register so that reset
   // removes them without waiting for a clock edge.
   assign in_mem = (cur_state == S_MEM);
   assign in_wb  = (cur_state == S_WB);

   assign MemRead  = in_mem & is_lw;
   assign MemWrite = in_mem & is_s;
   assign loadPC   = in_wb;
   assign RegWrite = in_wb & (is_r | is_i | is_lw);
   assign MemToReg = in_wb & is_lw;
   assign PCSrc    = in_wb & is_b & branch_ok & branch_cond;
   assign illegal  = in_wb & ~(is_r | is_i | is_s | is_lw | (is_b & branch_ok));
   assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Drives three multicycle_ctrl instances in parallel with shared random ready
// and flag inputs and independent random instruction streams:
//   0: SKIP_MEM=1, USE_HANDSHAKE=1, CNT_W=32
//   1: SKIP_MEM=0, USE_HANDSHAKE=1, CNT_W=4
//   2: SKIP_MEM=1, USE_HANDSHAKE=0, CNT_W=8
// Each instance is compared every cycle against a behavioural model that
// tracks which phase the current instruction is in and how many have retired.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int N = 3;
   localparam int CYCLES = 3000;

   // Instruction classes used by the reference model
   localparam int C_R = 0, C_I = 1, C_S = 2, C_B = 3, C_LW = 4, C_BAD = 5;

   logic        clk;
   logic        rst;
   logic        iReady, dReady, Zero, Lt;
   logic [31:0] instr [N];

   logic [3:0]  obs_alu      [N];
   logic        obs_alusrc   [N];
   logic        obs_regwrite [N];
   logic        obs_memtoreg [N];
   logic        obs_memread  [N];
   logic        obs_memwrite [N];
   logic        obs_loadpc   [N];
   logic        obs_pcsrc    [N];
   logic [2:0]  obs_state    [N];
   logic        obs_illegal  [N];
   logic [31:0] ir0;
   logic [3:0]  ir1;
   logic [7:0]  ir2;
   logic [31:0] obs_instret  [N];

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state per instance
   int     mPhase [N];
   longint mCount [N];
   int     mClass [N];
   int     pSkip  [N] = '{1, 0, 1};
   int     pHs    [N] = '{1, 1, 0};
   int     pWidth [N] = '{32, 4, 8};

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl #(.SKIP_MEM(1'b1), .USE_HANDSHAKE(1'b1), .CNT_W(32)) dut0 (
      .clk(clk), .rst(rst), .instr(instr[0]), .iReady(iReady), .dReady(dReady),
      .Zero(Zero), .Lt(Lt), .ALUCtrl(obs_alu[0]), .ALUSrc(obs_alusrc[0]),
      .RegWrite(obs_regwrite[0]), .MemToReg(obs_memtoreg[0]),
      .MemRead(obs_memread[0]), .MemWrite(obs_memwrite[0]),
      .loadPC(obs_loadpc[0]), .PCSrc(obs_pcsrc[0]), .state(obs_state[0]),
      .illegal(obs_illegal[0]), .instret(ir0));

   multicycle_ctrl #(.SKIP_MEM(1'b0), .USE_HANDSHAKE(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .instr(instr[1]), .iReady(iReady), .dReady(dReady),
      .Zero(Zero), .Lt(Lt), .ALUCtrl(obs_alu[1]), .ALUSrc(obs_alusrc[1]),
      .RegWrite(obs_regwrite[1]), .MemToReg(obs_memtoreg[1]),
      .MemRead(obs_memread[1]), .MemWrite(obs_memwrite[1]),
      .loadPC(obs_loadpc[1]), .PCSrc(obs_pcsrc[1]), .state(obs_state[1]),
      .illegal(obs_illegal[1]), .instret(ir1));

   multicycle_ctrl #(.SKIP_MEM(1'b1), .USE_HANDSHAKE(1'b0), .CNT_W(8)) dut2 (
      .clk(clk), .rst(rst), .instr(instr[2]), .iReady(iReady), .dReady(dReady),
      .Zero(Zero), .Lt(Lt), .ALUCtrl(obs_alu[2]), .ALUSrc(obs_alusrc[2]),
      .RegWrite(obs_regwrite[2]), .MemToReg(obs_memtoreg[2]),
      .MemRead(obs_memread[2]), .MemWrite(obs_memwrite[2]),
      .loadPC(obs_loadpc[2]), .PCSrc(obs_pcsrc[2]), .state(obs_state[2]),
      .illegal(obs_illegal[2]), .instret(ir2));

   // Widen the differently sized counters so they can be compared uniformly
   assign obs_instret[0] = ir0;
   assign obs_instret[1] = {28'd0, ir1};
   assign obs_instret[2] = {24'd0, ir2};

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Class of an instruction from its opcode
   function automatic int classOf(input logic [31:0] ins);
      case (ins[6:0])
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0100011: return C_S;
         7'b1100011: return C_B;
         7'b0000011: return C_LW;
         default:    return C_BAD;
      endcase
   endfunction

   // Expected ALU operation from mnemonic tables indexed by funct3
   function automatic logic [3:0] expAlu(input logic [31:0] ins);
      logic [3:0] base [8];
      int cls, f3;
      base = '{4'b0010, 4'b1001, 4'b0100, 4'b0100, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
      cls = classOf(ins);
      f3  = int'(ins[14:12]);
      if (cls == C_B) return 4'b0110;
      if (cls != C_R && cls != C_I) return 4'b0010;
      if (f3 == 5 && ins[30]) return 4'b1010;
      if (f3 == 0 && ins[30] && cls == C_R) return 4'b0110;
      return base[f3];
   endfunction

   function automatic bit branchSupported(input logic [31:0] ins);
      int f3 = int'(ins[14:12]);
      return (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
   endfunction

   function automatic bit branchTaken(input logic [31:0] ins, input logic z,
                                      input logic l);
      case (int'(ins[14:12]))
         0: return z;
         1: return !z;
         4: return l;
         5: return !l;
         default: return 1'b0;
      endcase
   endfunction

   // Random instruction with mixed classes, including unsupported opcodes
   function automatic logic [31:0] randInstr();
      logic [6:0]  badOps [6];
      logic [31:0] ins;
      int cls;
      badOps = '{7'h7F, 7'h00, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111};
      ins = $urandom;
      cls = $urandom_range(0, 5);
      case (cls)
         C_R:  ins[6:0] = 7'b0110011;
         C_I:  ins[6:0] = 7'b0010011;
         C_S:  ins[6:0] = 7'b0100011;
         C_B:  ins[6:0] = 7'b1100011;
         C_LW: ins[6:0] = 7'b0000011;
         default: ins[6:0] = badOps[$urandom_range(0, 5)];
      endcase
      // funct3=011 has no distinct ALU op here, so keep R/I away from it
      if ((cls == C_R || cls == C_I) && ins[14:12] == 3'b011) ins[14:12] = 3'b010;
      return ins;
   endfunction

   // New random inputs for this cycle; instructions only change during IF
   task automatic applyStimulus();
      iReady = ($urandom_range(0, 9) < 6);
      dReady = ($urandom_range(0, 9) < 6);
      Zero   = $urandom_range(0, 1);
      Lt     = $urandom_range(0, 1);
      for (int k = 0; k < N; k++)
         if (mPhase[k] == 0) instr[k] = randInstr();
   endtask

   // Compare every output of instance k against the model's view of it
   task automatic checkInstance(input int k);
      int  ph, cls;
      bit  illeg;
      longint mask;
      ph    = mPhase[k];
      cls   = classOf(instr[k]);
      illeg = (cls == C_BAD) || (cls == C_B && !branchSupported(instr[k]));
      mask  = (64'd1 << pWidth[k]) - 1;
      checkOutput($sformatf("state[%0d]", k), 32'(obs_state[k]), 32'(ph));
      checkOutput($sformatf("ALUCtrl[%0d]", k), 32'(obs_alu[k]), 32'(expAlu(instr[k])));
      checkOutput($sformatf("ALUSrc[%0d]", k), 32'(obs_alusrc[k]),
                  32'(!(cls == C_R || cls == C_B)));
      checkOutput($sformatf("RegWrite[%0d]", k), 32'(obs_regwrite[k]),
                  32'(ph == 4 && (cls == C_R || cls == C_I || cls == C_LW)));
      checkOutput($sformatf("MemToReg[%0d]", k), 32'(obs_memtoreg[k]),
                  32'(ph == 4 && cls == C_LW));
      checkOutput($sformatf("MemRead[%0d]", k), 32'(obs_memread[k]),
                  32'(ph == 3 && cls == C_LW));
      checkOutput($sformatf("MemWrite[%0d]", k), 32'(obs_memwrite[k]),
                  32'(ph == 3 && cls == C_S));
      checkOutput($sformatf("loadPC[%0d]", k), 32'(obs_loadpc[k]), 32'(ph == 4));
      checkOutput($sformatf("PCSrc[%0d]", k), 32'(obs_pcsrc[k]),
                  32'(ph == 4 && cls == C_B && branchTaken(instr[k], Zero, Lt)));
      checkOutput($sformatf("illegal[%0d]", k), 32'(obs_illegal[k]), 32'(ph == 4 && illeg));
      checkOutput($sformatf("instret[%0d]", k), obs_instret[k], 32'(mCount[k] & mask));
   endtask

   // Advance the model by one clock using the inputs present this cycle
   task automatic stepModel(input int k);
      bit iOk, dOk, memOp;
      iOk   = pHs[k] ? iReady : 1'b1;
      dOk   = pHs[k] ? dReady : 1'b1;
      memOp = (classOf(instr[k]) == C_S) || (classOf(instr[k]) == C_LW);
      case (mPhase[k])
         0: if (iOk) mPhase[k] = 1;
         1: mPhase[k] = 2;
         2: mPhase[k] = (memOp || !pSkip[k]) ? 3 : 4;
         3: if (!memOp || dOk) mPhase[k] = 4;
         default: begin
            mPhase[k] = 0;
            mCount[k]++;
         end
      endcase
   endtask

   // Directed reset-during-load sequence, then the randomized run
   initial begin
      int waitCnt;
      rst = 1'b0;
      iReady = 1'b0; dReady = 1'b0; Zero = 1'b0; Lt = 1'b0;
      instr[0] = 32'h0000_2003;
      instr[1] = 32'h0000_0013;
      instr[2] = 32'h0000_0013;
      for (int k = 0; k < N; k++) begin
         mPhase[k] = 0;
         mCount[k] = 0;
         mClass[k] = 0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checkOutput($sformatf("resetState[%0d]", k), 32'(obs_state[k]), 32'd0);
         checkOutput($sformatf("resetInstret[%0d]", k), obs_instret[k], 32'd0);
         checkOutput($sformatf("resetLoadPC[%0d]", k), 32'(obs_loadpc[k]), 32'd0);
      end

      rst = 1'b1;
      iReady = 1'b1;
      waitCnt = 0;
      while (obs_state[0] != 3'd3 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("reachMem", 32'(obs_state[0]), 32'd3);
      repeat (3) begin
         checkOutput("lwMemHeld", 32'(obs_state[0]), 32'd3);
         checkOutput("lwMemRead", 32'(obs_memread[0]), 32'd1);
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      checkOutput("asyncMemRead", 32'(obs_memread[0]), 32'd0);
      checkOutput("asyncState", 32'(obs_state[0]), 32'd0);
      checkOutput("asyncInstret0", obs_instret[0], 32'd0);
      checkOutput("asyncInstret1", obs_instret[1], 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int c = 0; c < CYCLES; c++) begin
         applyStimulus();
         #1;
         for (int k = 0; k < N; k++) checkInstance(k);
         for (int k = 0; k < N; k++) stepModel(k);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised control unit and state machine for the multicycle RV32 processor. It decodes opcode, funct3 and funct7[5], and produces ALU and datapath control plus memory strobes. It sequences IF/ID/EX/MEM/WB with optional MEM skipping and ready handshakes on instruction and data memory. It adds BNE/BLT/BGE branches, illegal-instruction flagging and a retired-instruction counter, and drops in beside the existing datapath.

Parameters:
SKIP_MEM, 1, 1: non-load/store instructions go EX->WB; 0: every instruction visits MEM
USE_HANDSHAKE, 1, 1: IF waits for iReady and MEM waits for dReady; 0: ready inputs ignored (treated as 1)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  current instruction (stable from ID through WB)
iReady  in  1  instruction memory ready
dReady  in  1  data memory ready
Zero  in  1  ALU result == 0
Lt  in  1  signed rs1 < rs2, from datapath comparator
ALUCtrl  out  4  ALU operation
ALUSrc  out  1  0: rs2, 1: immediate
RegWrite  out  1  register file write enable
MemToReg  out  1  writeback select: 1 = dReadData
MemRead  out  1  data memory read strobe
MemWrite  out  1  data memory write strobe
loadPC  out  1  PC register update enable
PCSrc  out  1  1: PC <= branch target
state  out  3  current state (IF=0, ID=1, EX=2, MEM=3, WB=4)
illegal  out  1  unsupported opcode or branch funct3; valid while in WB
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst=0, asynchronous): state=IF and instret=0 immediately. Because every strobe is decoded from state, all strobes are 0 immediately. Reset mid-MEM drops MemRead/MemWrite in the same cycle. First IF begins on the first clk edge after release.
- Opcodes: R 0110011, I 0010011, S 0100011, B 1100011, LW 0000011. Any other opcode is illegal.
- ALUSrc: 0 for R and B; 1 for all others.
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010.
- ALUCtrl for R: decoded from funct3 and funct7[5].
- ALUCtrl for I: decoded from funct3; funct7[5] is honoured only for funct3=101 (SRAI).
- ALUCtrl for S, LW and illegal opcodes: ADD. ALUCtrl for B: SUB.
- Branch condition by funct3: 000 Zero; 001 !Zero; 100 Lt; 101 !Lt. Any other branch funct3 is illegal, condition false.
- Transitions:
  - IF->ID when iReady; otherwise IF holds.
  - ID->EX unconditionally.
  - EX->MEM if opcode is S or LW, or if SKIP_MEM=0; otherwise EX->WB.
  - MEM->WB when the instruction is not S/LW, or when dReady=1; otherwise MEM holds.
  - WB->IF unconditionally. Undefined state encodings go to IF.
- MEM strobes: MemRead=1 for LW, MemWrite=1 for S. Both stay high for every MEM cycle until the dReady cycle inclusive. MEM for other opcodes asserts nothing.
- WB:
  - loadPC=1.
  - RegWrite=1 for R, I and LW only; never for illegal.
  - MemToReg=1 for LW.
  - PCSrc=1 for B with condition true.
  - illegal=1 if the opcode or branch funct3 is unsupported.
- Outside WB: loadPC, RegWrite, MemToReg, PCSrc and illegal are 0. Only one of MemRead/MemWrite is ever high, and only in MEM.
- instret increments on each clk edge leaving WB, including illegal instructions. It wraps modulo 2^CNT_W.
- Latency with ready always high: R/I/B take 4 cycles (SKIP_MEM=1) or 5 (SKIP_MEM=0). S/LW take 5 cycles. Each wait cycle adds 1.
- A ready input high outside its wait state is ignored.

Test Plan:
- Reset and first fetch: rst low mid-MEM with LW → MemRead falls without waiting for clk, state=0, instret=0. Release with iReady=1, add x1,x2,x3 → states 0,1,2,4,0; RegWrite and loadPC high only in WB; ALUCtrl=0010, ALUSrc=0.
- Load with handshake: lw (opcode 0000011), dReady low 3 cycles → MEM held 4 cycles, MemRead high throughout, then WB with MemToReg=1, RegWrite=1; instret +1.
- Branches: bne with Zero=0 → PCSrc=1 in WB. bge with Lt=1 → PCSrc=0. beq with Zero=1 → PCSrc=1. RegWrite=0 in all three; ALUCtrl=0110 throughout.
- SKIP_MEM=0, xori (funct3 100) → 5-cycle sequence 0,1,2,3,4; MEM has no strobes; ALUCtrl=0101, ALUSrc=1.
- Illegal: instr=32'h0000007F, and a branch with funct3=010 → illegal=1 in WB, RegWrite, MemWrite and PCSrc all 0, loadPC=1, instret increments.
- Counter wrap with CNT_W=4: retire 17 instructions → instret=1. srai (funct7[5]=1, funct3=101) → ALUCtrl=1010.
